// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared widths, FSM states and round function for the Feistel encryptor
package cipher_pkg;

  localparam int BLOCK_W = 64;
  localparam int HALF_W  = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Carry out of the 32-bit add is intentionally dropped before the XOR mask.
  function automatic logic [HALF_W-1:0] round_f(input logic [HALF_W-1:0] r,
                                                input logic [BLOCK_W-1:0] k);
    round_f = (r + k[HALF_W-1:0]) ^ k[BLOCK_W-1:HALF_W];
  endfunction

endpackage

// File: rtl/feistel_encryptor_if.sv
// rtl/feistel_encryptor_if.sv - plaintext/key input and ciphertext output handshake bundle
interface feistel_encryptor_if;
  import cipher_pkg::*;

  logic [BLOCK_W-1:0] key1;
  logic [BLOCK_W-1:0] key2;
  logic [BLOCK_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  modport master (
    output key1, key2, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  key1, key2, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy
  );

endinterface

// File: rtl/feistel_round.sv
// rtl/feistel_round.sv - one combinational Feistel round: L' = R, R' = L ^ F(R, K)
module feistel_round
  import cipher_pkg::*;
(
  input  logic [HALF_W-1:0]  l,
  input  logic [HALF_W-1:0]  r,
  input  logic [BLOCK_W-1:0] k,
  output logic [HALF_W-1:0]  l_next,
  output logic [HALF_W-1:0]  r_next
);

  assign l_next = r;
  assign r_next = l ^ round_f(r, k);

endmodule

// File: rtl/feistel_encryptor.sv
// rtl/feistel_encryptor.sv - iterative Feistel encryptor, one round per clock, keys latched at acceptance
module feistel_encryptor
  import cipher_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              reset,
  feistel_encryptor_if.slave bus
);

  localparam int              CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [HALF_W-1:0]  l;
  logic [HALF_W-1:0]  r;
  logic [HALF_W-1:0]  l_next;
  logic [HALF_W-1:0]  r_next;
  logic [BLOCK_W-1:0] k1;
  logic [BLOCK_W-1:0] k2;
  logic [BLOCK_W-1:0] k_sel;

  // Even rounds use key1, odd rounds key2; the counter LSB is the round parity.
  assign k_sel = cnt[0] ? k2 : k1;

  feistel_round u_round (
    .l      (l),
    .r      (r),
    .k      (k_sel),
    .l_next (l_next),
    .r_next (r_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      l   <= '0;
      r   <= '0;
      k1  <= '0;
      k2  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            l   <= bus.in_data[BLOCK_W-1:HALF_W];
            r   <= bus.in_data[HALF_W-1:0];
            k1  <= bus.key1;
            k2  <= bus.key2;
            cnt <= '0;
          end
        end
        RUN: begin
          l   <= l_next;
          r   <= r_next;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = {l, r};

endmodule
